// File: rtl/divfps_iter_if.sv
// Start/busy/done handshake and operand/result bus of the iterative FP32 divider.
interface divfps_iter_if;
  logic        start_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [2:0]  frm_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] c_o;
  logic [4:0]  fflags_o;

  modport master (
    output start_i, rs1_i, rs2_i, frm_i,
    input  busy_o, done_o, c_o, fflags_o
  );

  modport slave (
    input  start_i, rs1_i, rs2_i, frm_i,
    output busy_o, done_o, c_o, fflags_o
  );
endinterface

// File: rtl/divfps_iter.sv
// Iterative FP32 divider: one restoring-division quotient bit per cycle, IEEE rounding and
// FFLAGS {NV,DZ,OF,UF,NX}. Special operands finish in two cycles, normal ones in thirty.
module divfps_iter (
  input  logic   clk_i,
  input  logic   rst_i,
  divfps_iter_if.slave io
);
  // 24 significand bits + guard + round + one extra bit for quotients below 1.0
  localparam int unsigned Iter = 27;

  typedef enum logic [2:0] {StIdle, StCheck, StDiv, StRound, StDone} state_e;
  state_e state_q, state_d;

  logic [31:0]       a_q, a_d, b_q, b_d, c_q, c_d;
  logic [2:0]        frm_q, frm_d;
  logic              sign_q, sign_d;
  logic signed [9:0] exp_q, exp_d;
  logic [25:0]       rem_q, rem_d;
  logic [23:0]       div_q, div_d;
  logic [26:0]       quo_q, quo_d;
  logic [4:0]        cnt_q, cnt_d, flags_q, flags_d;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    lzc24 = 5'd24;
    for (int i = 0; i < 24; i++) if (v[i]) lzc24 = 5'(23 - i);
  endfunction

  // Operand classification, valid while in CHECK
  logic sgn, frm_bad, nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b;
  assign sgn     = a_q[31] ^ b_q[31];
  assign frm_bad = frm_q > 3'd4;
  assign nan_a   = (&a_q[30:23]) & (|a_q[22:0]);
  assign nan_b   = (&b_q[30:23]) & (|b_q[22:0]);
  assign snan_a  = nan_a & ~a_q[22];
  assign snan_b  = nan_b & ~b_q[22];
  assign inf_a   = (&a_q[30:23]) & ~(|a_q[22:0]);
  assign inf_b   = (&b_q[30:23]) & ~(|b_q[22:0]);
  assign zero_a  = ~(|a_q[30:0]);
  assign zero_b  = ~(|b_q[30:0]);

  logic        is_special;
  logic [31:0] spec_c;
  logic [4:0]  spec_flags;

  // Special-operand results, resolved entirely in CHECK
  always_comb begin
    is_special = 1'b1;
    spec_c     = '0;
    spec_flags = '0;
    if (frm_bad | nan_a | nan_b | (zero_a & zero_b) | (inf_a & inf_b)) begin
      spec_c     = 32'h7FC0_0000;
      spec_flags = {frm_bad | snan_a | snan_b | (zero_a & zero_b) | (inf_a & inf_b), 4'b0};
    end else if (inf_a) begin
      spec_c = {sgn, 8'hFF, 23'd0};
    end else if (inf_b) begin
      spec_c = {sgn, 31'd0};
    end else if (zero_b) begin
      spec_c     = {sgn, 8'hFF, 23'd0};
      spec_flags = 5'b01000;
    end else if (zero_a) begin
      spec_c = {sgn, 31'd0};
    end else begin
      is_special = 1'b0;
    end
  end

  // Subnormals are normalised up front so the divider always sees 1.xxx significands
  logic [23:0]       ma_raw, mb_raw, ma_n, mb_n;
  logic [4:0]        lz_a, lz_b;
  logic signed [9:0] ea_n, eb_n;
  assign ma_raw = {|a_q[30:23], a_q[22:0]};
  assign mb_raw = {|b_q[30:23], b_q[22:0]};
  assign lz_a   = lzc24(ma_raw);
  assign lz_b   = lzc24(mb_raw);
  assign ma_n   = ma_raw << lz_a;
  assign mb_n   = mb_raw << lz_b;
  assign ea_n   = (a_q[30:23] == 8'd0) ? (10'sd1 - $signed({5'd0, lz_a}))
                                       : $signed({2'd0, a_q[30:23]});
  assign eb_n   = (b_q[30:23] == 8'd0) ? (10'sd1 - $signed({5'd0, lz_b}))
                                       : $signed({2'd0, b_q[30:23]});

  // Restoring step; bit 26 of the trial is the borrow
  logic [26:0] trial;
  logic [25:0] rem_nxt;
  assign trial   = {1'b0, rem_q} - {3'b0, div_q};
  assign rem_nxt = trial[26] ? rem_q : trial[25:0];

  logic [26:0]       q_norm, q_sh;
  logic signed [9:0] e_norm, sh_full;
  logic [4:0]        sh;
  logic [7:0]        exp_f;
  logic [30:0]       sum;
  logic              tiny, lost, rb, st, inexact, inc, ovf, to_inf;
  logic [31:0]       rnd_c;
  logic [4:0]        rnd_flags;

  // Normalise, denormalise if tiny, then round and pack with overflow handling
  always_comb begin
    q_norm  = quo_q[26] ? quo_q : {quo_q[25:0], 1'b0};
    e_norm  = quo_q[26] ? exp_q : exp_q - 10'sd1;
    tiny    = (e_norm <= 10'sd0);
    sh_full = 10'sd1 - e_norm;
    sh      = '0;
    if (tiny) sh = (sh_full > 10'sd27) ? 5'd27 : sh_full[4:0];
    q_sh    = q_norm >> sh;
    lost    = |(q_norm & ~({27{1'b1}} << sh));
    // After a denormalising shift the hidden bit is 0, so it doubles as the exponent field
    exp_f   = tiny ? {7'd0, q_sh[26]} : e_norm[7:0];
    rb      = q_sh[2];
    st      = (|q_sh[1:0]) | (|rem_q) | lost;
    inexact = rb | st;
    case (frm_q)
      3'd0:    inc = rb & (st | q_sh[3]);
      3'd2:    inc = sign_q & inexact;
      3'd3:    inc = ~sign_q & inexact;
      3'd4:    inc = rb;
      default: inc = 1'b0;
    endcase
    // Mantissa carry ripples into the exponent field, including subnormal -> min-normal
    sum    = {exp_f, q_sh[25:3]} + {30'd0, inc};
    ovf    = (e_norm >= 10'sd255) | (sum[30:23] == 8'hFF);
    to_inf = (frm_q == 3'd0) | (frm_q == 3'd4) | ((frm_q == 3'd3) & ~sign_q)
           | ((frm_q == 3'd2) & sign_q);
    if (ovf) begin
      rnd_c     = to_inf ? {sign_q, 8'hFF, 23'd0} : {sign_q, 8'hFE, 23'h7F_FFFF};
      rnd_flags = 5'b00101;
    end else begin
      rnd_c     = {sign_q, sum};
      rnd_flags = {3'b000, tiny & inexact, inexact};
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (io.start_i) state_d = StCheck;
      StCheck: state_d = is_special ? StDone : StDiv;
      StDiv:   if (cnt_q == 5'(Iter - 1)) state_d = StRound;
      StRound: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake and result outputs
  always_comb begin
    io.busy_o   = (state_q != StIdle);
    io.done_o   = (state_q == StDone);
    io.c_o      = c_q;
    io.fflags_o = flags_q;
  end

  // Datapath next-state: capture, setup, iterate, round
  always_comb begin
    a_d = a_q; b_d = b_q; frm_d = frm_q; sign_d = sign_q; exp_d = exp_q;
    rem_d = rem_q; div_d = div_q; quo_d = quo_q; cnt_d = cnt_q;
    c_d = c_q; flags_d = flags_q;
    unique case (state_q)
      StIdle: begin
        if (io.start_i) begin
          a_d   = io.rs1_i;
          b_d   = io.rs2_i;
          frm_d = io.frm_i;
        end
      end
      StCheck: begin
        sign_d = sgn;
        if (is_special) begin
          c_d     = spec_c;
          flags_d = spec_flags;
        end else begin
          exp_d = ea_n - eb_n + 10'sd127;
          rem_d = {2'b00, ma_n};
          div_d = mb_n;
          quo_d = '0;
          cnt_d = '0;
        end
      end
      StDiv: begin
        quo_d = {quo_q[25:0], ~trial[26]};
        rem_d = rem_nxt << 1;
        cnt_d = cnt_q + 5'd1;
      end
      StRound: begin
        c_d     = rnd_c;
        flags_d = rnd_flags;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q <= '0; b_q <= '0; frm_q <= '0; sign_q <= 1'b0; exp_q <= '0;
      rem_q <= '0; div_q <= '0; quo_q <= '0; cnt_q <= '0;
      c_q <= '0; flags_q <= '0;
    end else begin
      a_q <= a_d; b_q <= b_d; frm_q <= frm_d; sign_q <= sign_d; exp_q <= exp_d;
      rem_q <= rem_d; div_q <= div_d; quo_q <= quo_d; cnt_q <= cnt_d;
      c_q <= c_d; flags_q <= flags_d;
    end
  end
endmodule
